// File: rtl/rps_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : rps_match_scorer
// Brief    : Match scorekeeper for stone-paper-scissors round results; optional
//            consecutive-win streak tracking enabled by RPS_STREAK_EN.
// Revision : 1.0  initial release
// ============================================================================
module rps_match_scorer #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid,
    input  logic [1:0]         res_code,
    input  logic               clear_match,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   tie_cnt,
    output logic [CNT_W-1:0]   inv_cnt,
    output logic [1:0]         match_state,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               res_drop,
    output logic [SCORE_W-1:0] streak_len,
    output logic [1:0]         streak_owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [SCORE_W-1:0] c_win_target = SCORE_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0]   c_cnt_max    = '1;

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_p1, w_p1_nxt, r_p2, w_p2_nxt;
    logic [CNT_W-1:0]   r_round, w_round_nxt, r_tie, w_tie_nxt, r_inv, w_inv_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_over, r_drop, w_drop_nxt;
    logic [SCORE_W-1:0] w_p1_inc, w_p2_inc;
    logic               w_take;

    assign w_p1_inc = r_p1 + 1'b1;
    assign w_p2_inc = r_p2 + 1'b1;
    // A strobe is scored only while the match is open and not being cleared.
    assign w_take   = res_valid && !clear_match &&
                      (r_state == ST_IDLE || r_state == ST_PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_p1     <= '0;
            r_p2     <= '0;
            r_round  <= '0;
            r_tie    <= '0;
            r_inv    <= '0;
            r_winner <= 2'b00;
            r_over   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_p1     <= w_p1_nxt;
            r_p2     <= w_p2_nxt;
            r_round  <= w_round_nxt;
            r_tie    <= w_tie_nxt;
            r_inv    <= w_inv_nxt;
            r_winner <= w_winner_nxt;
            r_over   <= (w_state_nxt == ST_DONE);
            r_drop   <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_round_nxt  = r_round;
        w_tie_nxt    = r_tie;
        w_inv_nxt    = r_inv;
        w_winner_nxt = r_winner;
        w_drop_nxt   = 1'b0;
        if (clear_match) begin
            w_state_nxt  = ST_IDLE;
            w_p1_nxt     = '0;
            w_p2_nxt     = '0;
            w_round_nxt  = '0;
            w_tie_nxt    = '0;
            w_inv_nxt    = '0;
            w_winner_nxt = 2'b00;
            w_drop_nxt   = res_valid;
        end else begin
            case (r_state)
                ST_IDLE, ST_PLAY: begin
                    if (w_take) begin
                        if (res_code == 2'b11) begin
                            if (r_inv != c_cnt_max) w_inv_nxt = r_inv + 1'b1;
                        end else begin
                            if (r_round != c_cnt_max) w_round_nxt = r_round + 1'b1;
                            w_state_nxt = ST_PLAY;
                            case (res_code)
                                2'b01: begin
                                    w_p1_nxt = w_p1_inc;
                                    if (w_p1_inc == c_win_target) begin
                                        w_state_nxt  = ST_DONE;
                                        w_winner_nxt = 2'b01;
                                    end
                                end
                                2'b10: begin
                                    w_p2_nxt = w_p2_inc;
                                    if (w_p2_inc == c_win_target) begin
                                        w_state_nxt  = ST_DONE;
                                        w_winner_nxt = 2'b10;
                                    end
                                end
                                default: begin
                                    if (r_tie != c_cnt_max) w_tie_nxt = r_tie + 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: w_drop_nxt = res_valid;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef RPS_STREAK_EN
    localparam logic [SCORE_W-1:0] c_streak_max = '1;

    logic [SCORE_W-1:0] r_slen, w_slen_nxt;
    logic [1:0]         r_sown, w_sown_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slen <= '0;
            r_sown <= 2'b00;
        end else begin
            r_slen <= w_slen_nxt;
            r_sown <= w_sown_nxt;
        end
    end

    always_comb begin
        w_slen_nxt = r_slen;
        w_sown_nxt = r_sown;
        if (clear_match) begin
            w_slen_nxt = '0;
            w_sown_nxt = 2'b00;
        end else if (w_take) begin
            case (res_code)
                2'b00: begin
                    w_slen_nxt = '0;
                    w_sown_nxt = 2'b00;
                end
                2'b01, 2'b10: begin
                    if (r_sown == res_code) begin
                        if (r_slen != c_streak_max) w_slen_nxt = r_slen + 1'b1;
                    end else begin
                        w_slen_nxt = SCORE_W'(1);
                        w_sown_nxt = res_code;
                    end
                end
                default: ;
            endcase
        end
    end

    assign streak_len   = r_slen;
    assign streak_owner = r_sown;
`else
    assign streak_len   = '0;
    assign streak_owner = 2'b00;
`endif

    assign p1_score     = r_p1;
    assign p2_score     = r_p2;
    assign round_cnt    = r_round;
    assign tie_cnt      = r_tie;
    assign inv_cnt      = r_inv;
    assign match_state  = r_state;
    assign match_over   = r_over;
    assign match_winner = r_winner;
    assign res_drop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_scorer
// Brief    : Randomized self-checking bench for rps_match_scorer against a
//            behavioural score model, plus directed literal scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_rps_match_scorer;

    localparam int WT   = 3;
    localparam int CMAX = 63;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       res_valid = 1'b0;
    logic [1:0] res_code = 2'b00;
    logic       clear_match = 1'b0;
    logic [3:0] p1_score, p2_score, streak_len;
    logic [5:0] round_cnt, tie_cnt, inv_cnt;
    logic [1:0] match_state, match_winner, streak_owner;
    logic       match_over, res_drop;

    rps_match_scorer #(.WIN_TARGET(WT), .SCORE_W(4), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_code(res_code),
        .clear_match(clear_match), .p1_score(p1_score), .p2_score(p2_score),
        .round_cnt(round_cnt), .tie_cnt(tie_cnt), .inv_cnt(inv_cnt),
        .match_state(match_state), .match_over(match_over),
        .match_winner(match_winner), .res_drop(res_drop),
        .streak_len(streak_len), .streak_owner(streak_owner)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state: plain integers, updated once per clock from the sampled inputs.
    int m_p1, m_p2, m_round, m_tie, m_inv, m_state, m_winner, m_drop, m_slen, m_sown;
    logic s_rst = 1'b0, s_clr = 1'b0, s_v = 1'b0;
    logic [1:0] s_code = 2'b00;

    always @(posedge clk) begin
        s_rst  <= reset;
        s_clr  <= clear_match;
        s_v    <= res_valid;
        s_code <= res_code;
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_zero();
        m_p1 = 0; m_p2 = 0; m_round = 0; m_tie = 0; m_inv = 0;
        m_state = 0; m_winner = 0; m_drop = 0; m_slen = 0; m_sown = 0;
    endtask

    task automatic model_step();
        int w;
        if (s_rst) model_zero();
        else if (s_clr) begin
            model_zero();
            m_drop = int'(s_v);
        end else if (m_state == 2) m_drop = int'(s_v);
        else begin
            m_drop = 0;
            if (s_v) begin
                if (s_code == 2'b11) m_inv = sat(m_inv + 1, CMAX);
                else begin
                    m_round = sat(m_round + 1, CMAX);
                    m_state = 1;
                    if (s_code == 2'b00) begin
                        m_tie = sat(m_tie + 1, CMAX);
                        m_slen = 0; m_sown = 0;
                    end else begin
                        w = int'(s_code);
                        if (w == 1) m_p1++; else m_p2++;
                        if (m_sown == w) m_slen = sat(m_slen + 1, SMAX);
                        else begin m_slen = 1; m_sown = w; end
                        if ((w == 1 ? m_p1 : m_p2) == WT) begin
                            m_state = 2; m_winner = w;
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_step();
        if (chk_en) begin
            chk("p1_score", p1_score, m_p1);
            chk("p2_score", p2_score, m_p2);
            chk("round_cnt", round_cnt, m_round);
            chk("tie_cnt", tie_cnt, m_tie);
            chk("inv_cnt", inv_cnt, m_inv);
            chk("match_state", match_state, m_state);
            chk("match_over", match_over, (m_state == 2) ? 1 : 0);
            chk("match_winner", match_winner, (m_state == 2) ? m_winner : 0);
            chk("res_drop", res_drop, m_drop);
`ifdef RPS_STREAK_EN
            chk("streak_len", streak_len, m_slen);
            chk("streak_owner", streak_owner, m_sown);
`else
            chk("streak_len", streak_len, 0);
            chk("streak_owner", streak_owner, 0);
`endif
        end
    end

    task automatic step(input logic r, input logic c, input logic v, input logic [1:0] code);
        @(negedge clk);
        reset = r; clear_match = c; res_valid = v; res_code = code;
        @(posedge clk);
        #1;
        reset = 1'b0; clear_match = 1'b0; res_valid = 1'b0; res_code = 2'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p1"}, p1_score, 0);
        chk({tag, "_p2"}, p2_score, 0);
        chk({tag, "_round"}, round_cnt, 0);
        chk({tag, "_tie"}, tie_cnt, 0);
        chk({tag, "_inv"}, inv_cnt, 0);
        chk({tag, "_state"}, match_state, 0);
        chk({tag, "_over"}, match_over, 0);
        chk({tag, "_winner"}, match_winner, 0);
        chk({tag, "_slen"}, streak_len, 0);
        chk({tag, "_sown"}, streak_owner, 0);
    endtask

    int exp_sl[5];
    int exp_so[5];
    logic [1:0] seq2[6];
    logic [1:0] seq6[5];

    initial begin
        model_zero();
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk_en = 1'b1;
        chk_all_zero("reset");
        chk("reset_drop", res_drop, 0);

        // Scenario 1: P1 sweeps three rounds.
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 2'b01);
            chk("s1_p1", p1_score, i);
        end
        chk("s1_over", match_over, 1);
        chk("s1_winner", match_winner, 2'b01);
        chk("s1_state", match_state, 2'b10);

        // Scenario 2: mixed results, P2 takes the match.
        step(1'b0, 1'b1, 1'b0, 2'b00);
        seq2 = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, seq2[i]);
        chk("s2_p1", p1_score, 1);
        chk("s2_p2", p2_score, 3);
        chk("s2_tie", tie_cnt, 1);
        chk("s2_inv", inv_cnt, 1);
        chk("s2_round", round_cnt, 5);
        chk("s2_winner", match_winner, 2'b10);
        chk("s2_state", match_state, 2'b10);

        // Scenario 3: strobe while DONE is dropped for exactly one cycle.
        step(1'b0, 1'b0, 1'b1, 2'b01);
        chk("s3_p1", p1_score, 1);
        chk("s3_p2", p2_score, 3);
        chk("s3_drop", res_drop, 1);
        step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("s3_drop_end", res_drop, 0);

        // Scenario 4: clear with a simultaneous strobe.
        step(1'b0, 1'b1, 1'b1, 2'b01);
        chk_all_zero("s4");
        chk("s4_drop", res_drop, 1);

        // Scenario 5: reset mid-match beats a simultaneous strobe.
        step(1'b0, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 1'b1, 2'b01);
        chk("s5_pre_p1", p1_score, 2);
        chk("s5_pre_state", match_state, 2'b01);
        step(1'b1, 1'b0, 1'b1, 2'b01);
        chk_all_zero("s5");
        chk("s5_drop", res_drop, 0);

        // Scenario 6: streak tracking.
        seq6 = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
`ifdef RPS_STREAK_EN
        exp_sl = '{1, 2, 0, 1, 1};
        exp_so = '{1, 1, 0, 2, 2};
`else
        exp_sl = '{0, 0, 0, 0, 0};
        exp_so = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, seq6[i]);
            chk("s6_slen", streak_len, exp_sl[i]);
            chk("s6_sown", streak_owner, exp_so[i]);
        end

        // Counter saturation via ties, then invalids.
        step(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("sat_round", round_cnt, CMAX);
        chk("sat_tie", tie_cnt, CMAX);
        chk("sat_state", match_state, 2'b01);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1, 2'b11);
        chk("sat_inv", inv_cnt, CMAX);
        chk("sat_round_hold", round_cnt, CMAX);

        // Invalid-only rounds keep the match in IDLE.
        step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b11);
        chk("inv_idle_state", match_state, 2'b00);
        chk("inv_idle_cnt", inv_cnt, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, c, v;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, c, v, 2'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
